// File: rtl/ir_tx_scheduler.sv
// IR transmit scheduler: one round-robin arbitrated launch per 10 Hz tick,
// with tick queueing, overrun counting and a start-timeout watchdog.
module ir_tx_scheduler #(
  parameter logic [3:0] IDLE_CMD      = 4'b0000,
  parameter bit         SEND_IDLE     = 1'b1,
  parameter int         START_TIMEOUT = 1023,
  parameter int         TO_WIDTH      = 10
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        TICK_CLK,
  input  logic [3:0]  REQ,
  input  logic [15:0] CMD_IN,
  output logic [3:0]  GNT,
  output logic        TX_START,
  output logic [3:0]  TX_CMD,
  input  logic        TX_BUSY,
  output logic [7:0]  OVERRUN_CNT,
  output logic        ERR_STICKY
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARB,
    S_SEND,
    S_WAIT
  } state_t;

  state_t              state_q, state_d;
  logic                tick_q, tick_d;
  logic                armed_q, armed_d;
  logic                pending_q, pending_d;
  logic [1:0]          rr_q, rr_d;
  logic [3:0]          gnt_q, gnt_d;
  logic                start_q, start_d;
  logic [3:0]          cmd_q, cmd_d;
  logic [7:0]          ovr_q, ovr_d;
  logic                err_q, err_d;
  logic [TO_WIDTH-1:0] to_q, to_d;

  logic                tick_pulse;
  logic [2:0]          pick;
  logic                found;
  logic [1:0]          win;

  // {found, index} of first request after ptr, wrapping modulo 4
  function automatic logic [2:0] rr_pick(
    input logic [3:0] req,
    input logic [1:0] ptr
  );
    logic [1:0] idx;
    rr_pick = 3'b000;
    for (int i = 1; i <= 4; i++) begin
      idx = ptr + 2'(i);
      if (!rr_pick[2] && req[idx])
        rr_pick = {1'b1, idx};
    end
  endfunction

  // armed_q masks the first cycle after reset so a high TICK_CLK
  // at release is not mistaken for a rising edge
  assign tick_pulse = armed_q & TICK_CLK & ~tick_q;
  assign pick       = rr_pick(REQ, rr_q);
  assign found      = pick[2];
  assign win        = pick[1:0];

  always_comb begin
    state_d   = state_q;
    tick_d    = TICK_CLK;
    armed_d   = 1'b1;
    pending_d = pending_q;
    rr_d      = rr_q;
    gnt_d     = 4'b0000;
    start_d   = 1'b0;
    cmd_d     = cmd_q;
    ovr_d     = ovr_q;
    err_d     = err_q;
    to_d      = to_q;

    unique case (state_q)
      S_IDLE: begin
        if (tick_pulse || pending_q) begin
          state_d   = S_ARB;
          pending_d = tick_pulse & pending_q;
        end
      end
      S_ARB: begin
        if (found) begin
          cmd_d   = CMD_IN[{win, 2'b00} +: 4];
          gnt_d   = 4'b0001 << win;
          start_d = 1'b1;
          rr_d    = win;
          to_d    = '0;
          state_d = S_SEND;
        end else if (SEND_IDLE) begin
          cmd_d   = IDLE_CMD;
          start_d = 1'b1;
          to_d    = '0;
          state_d = S_SEND;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SEND: begin
        if (TX_BUSY) begin
          state_d = S_WAIT;
        end else if (to_q == TO_WIDTH'(START_TIMEOUT)) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          to_d = to_q + TO_WIDTH'(1);
        end
      end
      S_WAIT: begin
        if (!TX_BUSY)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // only one tick can be queued; further ones are counted as lost
    if (state_q != S_IDLE && tick_pulse) begin
      if (!pending_q)
        pending_d = 1'b1;
      else if (ovr_q != 8'hFF)
        ovr_d = ovr_q + 8'd1;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q   <= S_IDLE;
      tick_q    <= 1'b0;
      armed_q   <= 1'b0;
      pending_q <= 1'b0;
      rr_q      <= 2'd3;
      gnt_q     <= 4'b0000;
      start_q   <= 1'b0;
      cmd_q     <= IDLE_CMD;
      ovr_q     <= 8'd0;
      err_q     <= 1'b0;
      to_q      <= '0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      armed_q   <= armed_d;
      pending_q <= pending_d;
      rr_q      <= rr_d;
      gnt_q     <= gnt_d;
      start_q   <= start_d;
      cmd_q     <= cmd_d;
      ovr_q     <= ovr_d;
      err_q     <= err_d;
      to_q      <= to_d;
    end
  end

  assign GNT         = gnt_q;
  assign TX_START    = start_q;
  assign TX_CMD      = cmd_q;
  assign OVERRUN_CNT = ovr_q;
  assign ERR_STICKY  = err_q;

endmodule

// File: tb/tb_ir_tx_scheduler.sv
// Directed bench for ir_tx_scheduler: vector table for arbitration,
// hand sequences for overrun, timeout and async reset.
module tb_ir_tx_scheduler;

  logic        CLK;
  logic        RESET;
  logic        TICK_CLK;
  logic [3:0]  REQ;
  logic [15:0] CMD_IN;
  logic        TX_BUSY;
  logic [3:0]  GNT, GNT2;
  logic        TX_START, TX_START2;
  logic [3:0]  TX_CMD, TX_CMD2;
  logic [7:0]  OVERRUN_CNT, OVERRUN_CNT2;
  logic        ERR_STICKY, ERR_STICKY2;

  int nvec = 0;
  int nerr = 0;

  ir_tx_scheduler dut (
    .CLK(CLK), .RESET(RESET), .TICK_CLK(TICK_CLK),
    .REQ(REQ), .CMD_IN(CMD_IN), .GNT(GNT),
    .TX_START(TX_START), .TX_CMD(TX_CMD), .TX_BUSY(TX_BUSY),
    .OVERRUN_CNT(OVERRUN_CNT), .ERR_STICKY(ERR_STICKY)
  );

  ir_tx_scheduler #(.SEND_IDLE(1'b0)) dut2 (
    .CLK(CLK), .RESET(RESET), .TICK_CLK(TICK_CLK),
    .REQ(REQ), .CMD_IN(CMD_IN), .GNT(GNT2),
    .TX_START(TX_START2), .TX_CMD(TX_CMD2), .TX_BUSY(TX_BUSY),
    .OVERRUN_CNT(OVERRUN_CNT2), .ERR_STICKY(ERR_STICKY2)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0]  req;
    logic [15:0] cmd;
    logic [3:0]  exp_gnt;
    logic [3:0]  exp_cmd;
    logic        exp_start2;
  } vec_t;

  vec_t tbl[10];

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    RESET    = 1'b0;
    TICK_CLK = 1'b0;
    TX_BUSY  = 1'b0;
    REQ      = 4'b0000;
    CMD_IN   = 16'h0000;
    cyc();
    cyc();
    RESET = 1'b1;
    cyc();
  endtask

  task automatic tick_lost();
    TICK_CLK = 1'b1;
    cyc();
    cyc();
    TICK_CLK = 1'b0;
    cyc();
    cyc();
  endtask

  initial begin
    bit seen;

    tbl[0] = '{4'b1111, 16'h4321, 4'b0001, 4'h1, 1'b1};
    tbl[1] = '{4'b1111, 16'h4321, 4'b0010, 4'h2, 1'b1};
    tbl[2] = '{4'b1111, 16'h4321, 4'b0100, 4'h3, 1'b1};
    tbl[3] = '{4'b1111, 16'h4321, 4'b1000, 4'h4, 1'b1};
    tbl[4] = '{4'b1111, 16'h4321, 4'b0001, 4'h1, 1'b1};
    tbl[5] = '{4'b1001, 16'h4321, 4'b1000, 4'h4, 1'b1};
    tbl[6] = '{4'b1001, 16'h4321, 4'b0001, 4'h1, 1'b1};
    tbl[7] = '{4'b0100, 16'h0A00, 4'b0100, 4'hA, 1'b1};
    tbl[8] = '{4'b0100, 16'h0B00, 4'b0100, 4'hB, 1'b1};
    tbl[9] = '{4'b0000, 16'hFFFF, 4'b0000, 4'h0, 1'b0};

    do_reset();
    chk("rst_gnt", 32'(GNT), 32'h0);
    chk("rst_start", 32'(TX_START), 32'h0);
    chk("rst_cmd", 32'(TX_CMD), 32'h0);
    chk("rst_ovr", 32'(OVERRUN_CNT), 32'h0);
    chk("rst_err", 32'(ERR_STICKY), 32'h0);

    for (int i = 0; i < 10; i++) begin
      REQ      = tbl[i].req;
      CMD_IN   = tbl[i].cmd;
      TICK_CLK = 1'b1;
      cyc();
      chk($sformatf("v%0d_early", i), 32'(TX_START), 32'h0);
      cyc();
      chk($sformatf("v%0d_start", i), 32'(TX_START), 32'h1);
      chk($sformatf("v%0d_gnt", i), 32'(GNT), 32'(tbl[i].exp_gnt));
      chk($sformatf("v%0d_cmd", i), 32'(TX_CMD), 32'(tbl[i].exp_cmd));
      chk($sformatf("v%0d_start2", i), 32'(TX_START2),
          32'(tbl[i].exp_start2));
      TICK_CLK = 1'b0;
      CMD_IN   = 16'h5555;
      cyc();
      cyc();
      cyc();
      TX_BUSY = 1'b1;
      repeat (20) cyc();
      chk($sformatf("v%0d_hold", i), 32'(TX_CMD), 32'(tbl[i].exp_cmd));
      TX_BUSY = 1'b0;
      repeat (3) cyc();
    end

    // overrun: transfer stuck busy while ticks keep arriving
    do_reset();
    REQ      = 4'b0001;
    CMD_IN   = 16'h0001;
    TICK_CLK = 1'b1;
    cyc();
    cyc();
    chk("ovr_start", 32'(TX_START), 32'h1);
    TX_BUSY  = 1'b1;
    TICK_CLK = 1'b0;
    cyc();
    cyc();
    tick_lost();
    chk("ovr_pending", 32'(dut.pending_q), 32'h1);
    chk("ovr_cnt0", 32'(OVERRUN_CNT), 32'h0);
    tick_lost();
    tick_lost();
    tick_lost();
    chk("ovr_cnt3", 32'(OVERRUN_CNT), 32'h3);
    TX_BUSY = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      if (TX_START) seen = 1'b1;
    end
    chk("ovr_restart", 32'(seen), 32'h1);
    TX_BUSY = 1'b1;
    repeat (300) tick_lost();
    chk("ovr_sat", 32'(OVERRUN_CNT), 32'd255);

    // start timeout: transmitter never answers
    do_reset();
    REQ      = 4'b0010;
    CMD_IN   = 16'h0050;
    TICK_CLK = 1'b1;
    cyc();
    cyc();
    chk("to_start", 32'(TX_START), 32'h1);
    chk("to_gnt", 32'(GNT), 32'h2);
    TICK_CLK = 1'b0;
    repeat (1023) cyc();
    chk("to_err_early", 32'(ERR_STICKY), 32'h0);
    cyc();
    chk("to_err_set", 32'(ERR_STICKY), 32'h1);
    TICK_CLK = 1'b1;
    cyc();
    cyc();
    chk("to_next_start", 32'(TX_START), 32'h1);
    chk("to_next_gnt", 32'(GNT), 32'h2);
    chk("to_next_cmd", 32'(TX_CMD), 32'h5);
    TX_BUSY  = 1'b1;
    TICK_CLK = 1'b0;
    cyc();
    cyc();
    chk("to_err_stays", 32'(ERR_STICKY), 32'h1);

    // async reset while in WAIT with nonzero status
    tick_lost();
    tick_lost();
    chk("ar_ovr_pre", 32'(OVERRUN_CNT), 32'h1);
    TICK_CLK = 1'b1;
    cyc();
    #2;
    RESET = 1'b0;
    #1;
    chk("ar_start", 32'(TX_START), 32'h0);
    chk("ar_gnt", 32'(GNT), 32'h0);
    chk("ar_cmd", 32'(TX_CMD), 32'h0);
    chk("ar_ovr", 32'(OVERRUN_CNT), 32'h0);
    chk("ar_err", 32'(ERR_STICKY), 32'h0);
    TX_BUSY = 1'b0;
    REQ     = 4'b0001;
    CMD_IN  = 16'h0007;
    cyc();
    #3;
    RESET = 1'b1;
    seen  = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cyc();
      if (TX_START) seen = 1'b1;
    end
    chk("ar_no_start", 32'(seen), 32'h0);
    TICK_CLK = 1'b0;
    cyc();
    TICK_CLK = 1'b1;
    cyc();
    cyc();
    chk("ar_tick_start", 32'(TX_START), 32'h1);
    chk("ar_tick_gnt", 32'(GNT), 32'h1);
    chk("ar_tick_cmd", 32'(TX_CMD), 32'h7);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
